// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath.
// Holds the 2-bit phase encoding decoded by both the layer sequencer and
// the layer datapath, so that both sides agree on the state values.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IN   = 2'b00,
        ST_BUFF = 2'b01,
        ST_OUT  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level strobe.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   strobe - level input
//   rise   - high for the cycle in which strobe is high and was low at the
//            previous edge
// The history register resets to 1 so a strobe held high through reset
// does not produce a spurious edge: it must drop and return first.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic rise
);

    logic strobe_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q_reg <= 1'b1;
        end else begin
            strobe_q_reg <= strobe;
        end
    end

    assign rise = strobe & ~strobe_q_reg;

endmodule

// File: rtl/layer_sequencer.sv
// Multi-layer phase controller: IN -> (BUFF -> OUT) x N_LAYERS -> DONE.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   changes      - level strobe; only its rising edge advances the sequence
//   finished     - abort request from OUT (returns to IN, layer holds)
//   beat_valid   - one data beat accepted this cycle
//   state        - current phase (nn_pkg encoding)
//   layer        - current layer index
//   beat_cnt     - beats counted in the current phase (saturating)
//   phase_start  - one-cycle pulse in the first cycle of a BUFF or OUT phase
//   done         - high exactly while state is DONE
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_LAYERS = 3,
    parameter int N_BEATS  = 8,
    parameter int LAYER_W  = 2,
    parameter int BEAT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               changes,
    input  logic               finished,
    input  logic               beat_valid,
    output logic [1:0]         state,
    output logic [LAYER_W-1:0] layer,
    output logic [BEAT_W-1:0]  beat_cnt,
    output logic               phase_start,
    output logic               done
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(N_BEATS - 1);
    localparam logic [BEAT_W-1:0]  BEAT_MAX   = {BEAT_W{1'b1}};

    state_t             state_reg, state_next;
    logic [LAYER_W-1:0] layer_reg, layer_next;
    logic [BEAT_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic               phase_start_reg, phase_start_next;
    logic               rise;

    rise_detect u_changes_rise (
        .clk    (clk),
        .reset  (reset),
        .strobe (changes),
        .rise   (rise)
    );

    always_comb begin
        state_next = state_reg;
        layer_next = layer_reg;

        case (state_reg)
            ST_IN: begin
                if (rise) begin
                    state_next = ST_BUFF;
                    layer_next = '0;
                end
            end
            ST_BUFF: begin
                // An early close and the terminal beat in the same cycle
                // both lead to OUT, so a single transition covers both.
                if (rise) begin
                    state_next = ST_OUT;
                end else if (beat_valid && (beat_cnt_reg == LAST_BEAT)) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                // rise takes priority over an abort in the same cycle.
                if (rise) begin
                    if (layer_reg == LAST_LAYER) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_BUFF;
                        layer_next = layer_reg + LAYER_W'(1);
                    end
                end else if (finished) begin
                    state_next = ST_IN;
                end
            end
            ST_DONE: begin
                state_next = ST_IN;
            end
            default: begin
                state_next = ST_IN;
            end
        endcase
    end

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        // A beat arriving on a transition cycle belongs to neither phase.
        if (state_next != state_reg) begin
            beat_cnt_next = '0;
        end else if ((state_reg == ST_BUFF) || (state_reg == ST_OUT)) begin
            if (beat_valid && (beat_cnt_reg != BEAT_MAX)) begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            end
        end else begin
            beat_cnt_next = '0;
        end
    end

    always_comb begin
        phase_start_next = (state_next != state_reg) &&
                           ((state_next == ST_BUFF) || (state_next == ST_OUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IN;
            layer_reg       <= '0;
            beat_cnt_reg    <= '0;
            phase_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            layer_reg       <= layer_next;
            beat_cnt_reg    <= beat_cnt_next;
            phase_start_reg <= phase_start_next;
        end
    end

    assign state       = state_reg;
    assign layer       = layer_reg;
    assign beat_cnt    = beat_cnt_reg;
    assign phase_start = phase_start_reg;
    assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with N_LAYERS=3, N_BEATS=4.
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       changes;
    logic       finished;
    logic       beat_valid;
    logic [1:0] state;
    logic [1:0] layer;
    logic [3:0] beat_cnt;
    logic       phase_start;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_LAYERS (3),
        .N_BEATS  (4),
        .LAYER_W  (2),
        .BEAT_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .changes     (changes),
        .finished    (finished),
        .beat_valid  (beat_valid),
        .state       (state),
        .layer       (layer),
        .beat_cnt    (beat_cnt),
        .phase_start (phase_start),
        .done        (done)
    );

    typedef struct {
        logic       rst;
        logic       ch;
        logic       fin;
        logic       bv;
        logic [1:0] st;
        logic [1:0] ly;
        logic [3:0] bc;
        logic       ps;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ch, input logic fin, input logic bv,
                       input logic [1:0] st, input logic [1:0] ly, input logic [3:0] bc,
                       input logic ps, input logic dn);
        vec_t v;
        v.rst = rst; v.ch = ch; v.fin = fin; v.bv = bv;
        v.st = st; v.ly = ly; v.bc = bc; v.ps = ps; v.dn = dn;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit later.
    task automatic step(input string name, input logic rst, input logic ch,
                        input logic fin, input logic bv,
                        input logic [1:0] st, input logic [1:0] ly, input logic [3:0] bc,
                        input logic ps, input logic dn);
        reset = rst; changes = ch; finished = fin; beat_valid = bv;
        @(posedge clk);
        #1;
        n_checks++;
        if (state !== st || layer !== ly || beat_cnt !== bc ||
            phase_start !== ps || done !== dn) begin
            n_fail++;
            $display("FAIL %s: got st=%b ly=%0d bc=%0d ps=%b dn=%b, expected st=%b ly=%0d bc=%0d ps=%b dn=%b",
                     name, state, layer, beat_cnt, phase_start, done, st, ly, bc, ps, dn);
        end else begin
            $display("ok   %s: st=%b ly=%0d bc=%0d ps=%b dn=%b",
                     name, state, layer, beat_cnt, phase_start, done);
        end
    endtask

    initial begin
        reset = 1'b1; changes = 1'b1; finished = 1'b0; beat_valid = 1'b0;

        //   rst ch fin bv   state  ly bc ps dn
        // Reset with changes held high, then no rise until it toggles.
        add(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 0);
        // Four beats close BUFF.
        add(0, 1, 0, 1, 2'b01, 0, 1, 0, 0);
        add(0, 1, 0, 1, 2'b01, 0, 2, 0, 0);
        add(0, 1, 0, 1, 2'b01, 0, 3, 0, 0);
        add(0, 1, 0, 1, 2'b10, 0, 0, 1, 0);
        add(0, 1, 0, 1, 2'b10, 0, 1, 0, 0);
        add(0, 0, 0, 0, 2'b10, 0, 1, 0, 0);
        // rise + finished in OUT at layer 0: rise wins, beat not counted.
        add(0, 1, 1, 1, 2'b01, 1, 0, 1, 0);
        add(0, 0, 0, 1, 2'b01, 1, 1, 0, 0);
        // Early close of BUFF by rise.
        add(0, 1, 0, 0, 2'b10, 1, 0, 1, 0);
        // finished only at layer 1: abort to IN, layer holds.
        add(0, 0, 1, 0, 2'b00, 1, 0, 0, 0);
        // Full pass; first BUFF closes on rise + terminal beat together.
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 0);
        add(0, 0, 0, 1, 2'b01, 0, 1, 0, 0);
        add(0, 0, 0, 1, 2'b01, 0, 2, 0, 0);
        add(0, 0, 0, 1, 2'b01, 0, 3, 0, 0);
        add(0, 1, 0, 1, 2'b10, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2'b01, 1, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        add(0, 1, 0, 0, 2'b10, 1, 0, 1, 0);
        add(0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
        add(0, 1, 0, 0, 2'b01, 2, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 2, 0, 0, 0);
        add(0, 1, 0, 0, 2'b10, 2, 0, 1, 0);
        add(0, 0, 0, 0, 2'b10, 2, 0, 0, 0);
        // Last OUT: rise (with finished) -> DONE, then IN regardless of inputs.
        add(0, 1, 1, 1, 2'b11, 2, 0, 0, 1);
        add(0, 0, 1, 1, 2'b00, 2, 0, 0, 0);
        // Walk to BUFF at layer 2 with beat_cnt=3, then reset.
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2'b10, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2'b01, 1, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        add(0, 1, 0, 0, 2'b10, 1, 0, 1, 0);
        add(0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
        add(0, 1, 0, 0, 2'b01, 2, 0, 1, 0);
        add(0, 0, 0, 1, 2'b01, 2, 1, 0, 0);
        add(0, 0, 0, 1, 2'b01, 2, 2, 0, 0);
        add(0, 0, 0, 1, 2'b01, 2, 3, 0, 0);
        add(1, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        // Edge history reset to 1: changes high right after reset is no rise.
        add(0, 1, 0, 0, 2'b00, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ch, vecs[i].fin, vecs[i].bv,
                 vecs[i].st, vecs[i].ly, vecs[i].bc, vecs[i].ps, vecs[i].dn);
        end

        // Hand-written: beat_cnt saturation in OUT, then abort clears it.
        step("sat_drop",  0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step("sat_buff",  0, 1, 0, 0, 2'b01, 0, 0, 1, 0);
        step("sat_drop2", 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
        step("sat_out",   0, 1, 0, 0, 2'b10, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat_beat%0d", i), 0, 0, 0, 1, 2'b10, 0,
                 (i + 1 > 15) ? 4'd15 : 4'(i + 1), 0, 0);
        end
        step("sat_abort", 0, 0, 1, 1, 2'b00, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised phase controller for the neural-network datapath, extending the IN → BUFF → OUT sequencer to a multi-layer pass. Tracks the current layer index and counts data beats per phase, and leaves BUFF automatically once a full beat count arrives. Edge-detects the `changes` strobe internally and emits phase-start and pass-done pulses. Sits between the input interface and the layer datapath, which decodes `state` and `layer`.

## Interface
- `N_LAYERS`, 3: layers per inference pass; must be ≥ 1.
- `N_BEATS`, 8: beats that complete a BUFF phase; must be ≥ 1.
- `LAYER_W`, 2: width of `layer`; 2^LAYER_W ≥ N_LAYERS.
- `BEAT_W`, 4: width of `beat_cnt`; 2^BEAT_W ≥ N_BEATS.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `changes` in 1: level strobe; only its rising edge advances the sequencer.
- `finished` in 1: abort or complete request from OUT.
- `beat_valid` in 1: one data beat accepted this cycle.
- `state` out 2: IN=00, BUFF=01, OUT=10, DONE=11.
- `layer` out LAYER_W: current layer index.
- `beat_cnt` out BEAT_W: beats counted in the current phase.
- `phase_start` out 1: one-cycle pulse in the first cycle of each new BUFF or OUT phase.
- `done` out 1: high exactly while `state`=DONE.

## Operation
- Rise detect: `rise = changes & ~changes_q`. `changes_q` resets to 1, so `changes` held high through reset gives no rise until it drops and returns.
- IN: on `rise`, go to BUFF and set layer=0.
- BUFF, in priority order:
  - On `rise`, go to OUT (early close).
  - Otherwise, on `beat_valid` with beat_cnt=N_BEATS−1, go to OUT.
- OUT, in priority order:
  - On `rise` with layer<N_LAYERS−1, go to BUFF and increment layer.
  - On `rise` with layer=N_LAYERS−1, go to DONE.
  - Otherwise, on `finished`, go to IN (abort; layer holds).
- DONE: unconditionally returns to IN next cycle; all inputs ignored.
- Illegal encodings cannot occur; the default branch returns to IN.
- `beat_cnt`:
  - Cleared to 0 on every state change.
  - In BUFF and OUT, increments on `beat_valid` and saturates at 2^BEAT_W−1.
  - In IN and DONE, held at 0.
- `phase_start` = registered flag, set when the next state is BUFF or OUT and differs from the current state.
- `beat_valid` in the same cycle as a transition is not counted in the new phase.

## Timing
- Reset values: `state`=00, `layer`=0, `beat_cnt`=0, `phase_start`=0, `done`=0, `changes_q`=1.
- Latency: an input sampled at edge E drives the next state, which appears on `state` immediately after edge E (1 cycle). No extra output register stage.
- `phase_start` and `done` are aligned with the first cycle of the new `state`.
- `reset` mid-pass overrides everything: the state returns to IN at the next edge and the pass is lost.
- `rise` and `finished` together in OUT: `rise` wins.
- `rise` and the terminal beat together in BUFF: a single transition to OUT.

## Structure
- Shared package `nn_pkg`: the 2-bit state typedef and the constants ST_IN, ST_BUFF, ST_OUT, ST_DONE. The datapath imports the same package.
- Sub-module `rise_detect`: register plus AND, reset value 1, reused for other strobes.
- Everything else lives in one module with separate next-state logic and register blocks.

## Test plan
With N_LAYERS=3 and N_BEATS=4:
- Reset with `changes`=1 held, then release → `state` stays 00 until `changes` goes 0 and back to 1, then 01 with `phase_start`=1.
- In BUFF, 4 `beat_valid` pulses on consecutive cycles → `state`=10 after the 4th, `beat_cnt`=0, `phase_start`=1.
- Full pass of three BUFF/OUT pairs, with a `rise` in each OUT → layer steps 0,1,2; the third OUT `rise` gives `state`=11 and `done`=1 for one cycle, then 00.
- OUT with `rise` and `finished` in the same cycle at layer 0 → `state`=01 and layer=1, not 00.
- OUT with `finished` only at layer 1 → `state`=00, layer=1, `beat_cnt`=0.
- `reset` pulsed during BUFF at layer 2 with `beat_cnt`=3 → next cycle all outputs at their reset values.
